// File: rtl/mem_arbiter_id.sv
// Round-robin arbiter sharing one line-wide memory port between the I-cache and D-cache.
// One transaction in flight; the owner gets a registered one-cycle ready/rdata response.
module mem_arbiter_id #(
   parameter int unsigned ADDR_W = 28,
   parameter int unsigned DATA_W = 128
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_read,
   input  logic              i_write,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [DATA_W-1:0] i_wdata,
   output logic [DATA_W-1:0] i_rdata,
   output logic              i_ready,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_ready,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_RESP  = 2'd2
   } state_e;

   state_e              state_q,     state_d;
   logic                last_d_q,    last_d_d;
   logic                owner_d_q,   owner_d_d;
   logic                mem_read_q,  mem_read_d;
   logic                mem_write_q, mem_write_d;
   logic [ADDR_W-1:0]   addr_q,      addr_d;
   logic [DATA_W-1:0]   wdata_q,     wdata_d;
   logic [DATA_W-1:0]   i_rdata_q,   i_rdata_d;
   logic [DATA_W-1:0]   d_rdata_q,   d_rdata_d;
   logic                i_ready_q,   i_ready_d;
   logic                d_ready_q,   d_ready_d;

   logic                req_i_c;
   logic                req_d_c;
   logic                grant_d_c;

   assign req_i_c = i_read | i_write;
   assign req_d_c = d_read | d_write;

   // Next-state, grant and response logic
   always_comb begin
      state_d     = state_q;
      last_d_d    = last_d_q;
      owner_d_d   = owner_d_q;
      mem_read_d  = mem_read_q;
      mem_write_d = mem_write_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      i_rdata_d   = i_rdata_q;
      d_rdata_d   = d_rdata_q;
      i_ready_d   = 1'b0;
      d_ready_d   = 1'b0;
      grant_d_c   = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (req_i_c || req_d_c) begin
               // On a tie the side that did not own the last transaction wins
               grant_d_c = req_d_c && (!req_i_c || !last_d_q);
               owner_d_d = grant_d_c;
               last_d_d  = grant_d_c;
               state_d   = ST_ISSUE;
               if (grant_d_c) begin
                  mem_write_d = d_write;
                  mem_read_d  = !d_write;
                  addr_d      = d_addr;
                  wdata_d     = d_wdata;
               end else begin
                  mem_write_d = i_write;
                  mem_read_d  = !i_write;
                  addr_d      = i_addr;
                  wdata_d     = i_wdata;
               end
            end
         end
         ST_ISSUE: begin
            if (mem_ready) begin
               mem_read_d  = 1'b0;
               mem_write_d = 1'b0;
               state_d     = ST_RESP;
               if (owner_d_q) begin
                  d_ready_d = 1'b1;
                  if (mem_read_q) d_rdata_d = mem_rdata;
               end else begin
                  i_ready_d = 1'b1;
                  if (mem_read_q) i_rdata_d = mem_rdata;
               end
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d     = ST_IDLE;
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         last_d_q    <= 1'b1;
         owner_d_q   <= 1'b0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         i_rdata_q   <= '0;
         d_rdata_q   <= '0;
         i_ready_q   <= 1'b0;
         d_ready_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         last_d_q    <= last_d_d;
         owner_d_q   <= owner_d_d;
         mem_read_q  <= mem_read_d;
         mem_write_q <= mem_write_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         i_rdata_q   <= i_rdata_d;
         d_rdata_q   <= d_rdata_d;
         i_ready_q   <= i_ready_d;
         d_ready_q   <= d_ready_d;
      end
   end

   assign mem_read  = mem_read_q;
   assign mem_write = mem_write_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign i_rdata   = i_rdata_q;
   assign i_ready   = i_ready_q;
   assign d_rdata   = d_rdata_q;
   assign d_ready   = d_ready_q;

endmodule

// File: tb/tb_mem_arbiter_id.sv
// Bench for mem_arbiter_id: queued cache requesters, a latency-programmable memory,
// and a transaction-level model checked against the DUT every cycle.
module tb_mem_arbiter_id;
   localparam int unsigned AW = 28;
   localparam int unsigned DW = 128;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          i_read = 1'b0, i_write = 1'b0;
   logic [AW-1:0] i_addr = '0;
   logic [DW-1:0] i_wdata = '0;
   logic [DW-1:0] i_rdata;
   logic          i_ready;
   logic          d_read = 1'b0, d_write = 1'b0;
   logic [AW-1:0] d_addr = '0;
   logic [DW-1:0] d_wdata = '0;
   logic [DW-1:0] d_rdata;
   logic          d_ready;
   logic          mem_read, mem_write;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata = '0;
   logic          mem_ready = 1'b0;

   always #5 clk = ~clk;

   mem_arbiter_id #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_read(i_read), .i_write(i_write), .i_addr(i_addr), .i_wdata(i_wdata),
      .i_rdata(i_rdata), .i_ready(i_ready),
      .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_ready(d_ready),
      .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
   );

   typedef struct packed {
      logic          side;   // 0 = I, 1 = D
      logic          wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
   } txn_t;

   txn_t iq[$];
   txn_t dq[$];
   txn_t exp_q[$];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int lat = 4;
   int mcnt = 0;
   int rst_ev = 0;

   always @(posedge clk) cyc <= cyc + 1;
   initial forever begin @(negedge rst_n); rst_ev++; end

   function automatic txn_t mk(input logic side, input logic wr,
                               input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
      txn_t t;
      t.side = side; t.wr = wr; t.addr = addr; t.wdata = wdata;
      return t;
   endfunction

   // Contents of the line memory as seen by reads
   function automatic logic [DW-1:0] line_of(input logic [AW-1:0] a);
      if (a == 28'h0000010) return {16{8'hA5}};
      return {4{4'hC, a}};
   endfunction

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b want %b (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic chkw(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic chki(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   // Memory: completes a strobe after lat cycles with a one-cycle mem_ready
   initial forever begin
      @(posedge clk); #1;
      if (!rst_n || mem_ready) begin
         mem_ready = 1'b0;
         mcnt = 0;
      end else if (mem_read || mem_write) begin
         mcnt++;
         if (mcnt >= lat) begin
            mem_ready = 1'b1;
            mem_rdata = mem_read ? line_of(mem_addr) : ~line_of(mem_addr);
         end
      end
   end

   // I-cache requester: holds each request until its ready pulse
   initial forever begin
      txn_t t;
      int   ev;
      @(posedge clk); #1;
      if (iq.size() > 0) begin
         t = iq.pop_front();
         i_read = !t.wr; i_write = t.wr; i_addr = t.addr; i_wdata = t.wdata;
         ev = rst_ev;
         for (int n = 0; ; n++) begin
            @(negedge clk);
            if (i_ready || rst_ev != ev) break;
            if (n >= 300) begin chk1("i_ready_timeout", 1'b0, 1'b1); break; end
         end
      end else begin
         i_read = 1'b0; i_write = 1'b0;
      end
   end

   // D-cache requester
   initial forever begin
      txn_t t;
      int   ev;
      @(posedge clk); #1;
      if (dq.size() > 0) begin
         t = dq.pop_front();
         d_read = !t.wr; d_write = t.wr; d_addr = t.addr; d_wdata = t.wdata;
         ev = rst_ev;
         for (int n = 0; ; n++) begin
            @(negedge clk);
            if (d_ready || rst_ev != ev) break;
            if (n >= 300) begin chk1("d_ready_timeout", 1'b0, 1'b1); break; end
         end
      end else begin
         d_read = 1'b0; d_write = 1'b0;
      end
   end

   // Transaction-level model and per-cycle compare
   txn_t          cur;
   logic          have_cur = 1'b0;
   logic          exp_ri = 1'b0, exp_rd = 1'b0;
   logic [DW-1:0] exp_irdata = '0, exp_drdata = '0;
   int            scnt = 0, last_scnt = 0, rdy_cyc = 0;
   logic          rdy_order[$];

   initial forever begin
      @(negedge clk);
      if (!rst_n) begin
         chk1("reset_outputs_zero",
              |{i_ready, d_ready, mem_read, mem_write, mem_addr, mem_wdata, i_rdata, d_rdata}, 1'b0);
         have_cur = 1'b0; exp_ri = 1'b0; exp_rd = 1'b0;
         exp_irdata = '0; exp_drdata = '0; scnt = 0;
      end else begin
         chk1("i_ready", i_ready, exp_ri);
         chk1("d_ready", d_ready, exp_rd);
         chkw("i_rdata", i_rdata, exp_irdata);
         chkw("d_rdata", d_rdata, exp_drdata);
         chk1("rw_exclusive", mem_read & mem_write, 1'b0);
         if (exp_ri || exp_rd) chk1("strobe_in_resp", mem_read | mem_write, 1'b0);
         if (i_ready) begin rdy_order.push_back(1'b0); rdy_cyc = cyc; end
         if (d_ready) begin rdy_order.push_back(1'b1); rdy_cyc = cyc; end
         exp_ri = 1'b0; exp_rd = 1'b0;
         if (mem_read || mem_write) begin
            if (!have_cur) begin
               if (exp_q.size() == 0) chk1("unexpected_txn", 1'b1, 1'b0);
               else begin cur = exp_q.pop_front(); have_cur = 1'b1; scnt = 0; end
            end
            if (have_cur) begin
               scnt++;
               chk1("mem_read", mem_read, !cur.wr);
               chk1("mem_write", mem_write, cur.wr);
               chkw("mem_addr", DW'(mem_addr), DW'(cur.addr));
               if (cur.wr) chkw("mem_wdata", mem_wdata, cur.wdata);
               if (mem_ready) begin
                  if (cur.side) begin
                     exp_rd = 1'b1;
                     if (!cur.wr) exp_drdata = line_of(cur.addr);
                  end else begin
                     exp_ri = 1'b1;
                     if (!cur.wr) exp_irdata = line_of(cur.addr);
                  end
                  have_cur = 1'b0;
                  last_scnt = scnt;
               end
            end
         end
      end
   end

   task automatic wait_done(input string name);
      int n;
      for (n = 0; n < 500; n++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !have_cur && iq.size() == 0 && dq.size() == 0 &&
             !i_read && !i_write && !d_read && !d_write && !i_ready && !d_ready) break;
      end
      if (n >= 500) chk1({name, "_timeout"}, 1'b0, 1'b1);
      repeat (2) @(negedge clk);
   endtask

   task automatic chk_order(input string name, input int n, input logic [7:0] sides);
      chki({name, "_count"}, rdy_order.size(), n);
      if (rdy_order.size() == n)
         for (int k = 0; k < n; k++) chk1({name, "_side"}, rdy_order[k], sides[k]);
   endtask

   initial begin
      int c0;
      // Reset with both sides requesting; after release I must win the first tie
      repeat (2) @(negedge clk);
      iq.push_back(mk(1'b0, 1'b0, 28'h0000100, '0));
      dq.push_back(mk(1'b1, 1'b0, 28'h0000200, '0));
      exp_q.push_back(mk(1'b0, 1'b0, 28'h0000100, '0));
      exp_q.push_back(mk(1'b1, 1'b0, 28'h0000200, '0));
      repeat (3) @(negedge clk);
      chk1("reset_i_read_seen", i_read, 1'b1);
      chk1("reset_mem_read", mem_read, 1'b0);
      rst_n = 1'b1;
      wait_done("reset_tie");
      chk_order("reset_tie", 2, 8'b10);

      // Lone I read, 4-cycle memory
      rdy_order.delete();
      lat = 4;
      c0 = cyc;
      iq.push_back(mk(1'b0, 1'b0, 28'h0000010, '0));
      exp_q.push_back(mk(1'b0, 1'b0, 28'h0000010, '0));
      wait_done("lone_i");
      chki("lone_i_strobe_cycles", last_scnt, 4);
      chki("lone_i_ready_cycle", rdy_cyc - c0, 6);
      chkw("lone_i_rdata", i_rdata, {16{8'hA5}});
      chk_order("lone_i", 1, 8'b0);

      // Lone D write, 3-cycle memory
      rdy_order.delete();
      lat = 3;
      c0 = cyc;
      dq.push_back(mk(1'b1, 1'b1, 28'h0000123, 128'h1234_5678_9ABC_DEF0_1357_9BDF_0246_CDEF));
      exp_q.push_back(mk(1'b1, 1'b1, 28'h0000123, 128'h1234_5678_9ABC_DEF0_1357_9BDF_0246_CDEF));
      wait_done("lone_d");
      chki("lone_d_strobe_cycles", last_scnt, 3);
      chki("lone_d_ready_cycle", rdy_cyc - c0, 5);
      chkw("lone_d_rdata_kept", d_rdata, {4{4'hC, 28'h0000200}});
      chk_order("lone_d", 1, 8'b1);

      // Both sides held: served I, D, I, D
      rdy_order.delete();
      lat = 2;
      c0 = cyc;
      iq.push_back(mk(1'b0, 1'b0, 28'h0000300, '0));
      iq.push_back(mk(1'b0, 1'b0, 28'h0000301, '0));
      dq.push_back(mk(1'b1, 1'b0, 28'h0000400, '0));
      dq.push_back(mk(1'b1, 1'b0, 28'h0000401, '0));
      exp_q.push_back(mk(1'b0, 1'b0, 28'h0000300, '0));
      exp_q.push_back(mk(1'b1, 1'b0, 28'h0000400, '0));
      exp_q.push_back(mk(1'b0, 1'b0, 28'h0000301, '0));
      exp_q.push_back(mk(1'b1, 1'b0, 28'h0000401, '0));
      wait_done("alternate");
      chk_order("alternate", 4, 8'b1010);
      chki("alternate_last_ready_cycle", rdy_cyc - c0, 16);

      // D write-back then D read with I pending: D write, I read, D read
      rdy_order.delete();
      dq.push_back(mk(1'b1, 1'b1, 28'h0000500, 128'hFEED_FACE_0000_1111_2222_3333_4444_5555));
      dq.push_back(mk(1'b1, 1'b0, 28'h0000500, '0));
      exp_q.push_back(mk(1'b1, 1'b1, 28'h0000500, 128'hFEED_FACE_0000_1111_2222_3333_4444_5555));
      exp_q.push_back(mk(1'b0, 1'b0, 28'h0000600, '0));
      exp_q.push_back(mk(1'b1, 1'b0, 28'h0000500, '0));
      @(negedge clk);
      iq.push_back(mk(1'b0, 1'b0, 28'h0000600, '0));
      wait_done("wb_alloc");
      chk_order("wb_alloc", 3, 8'b101);
      chkw("wb_alloc_d_rdata", d_rdata, {4{4'hC, 28'h0000500}});

      // Reset in the middle of ISSUE
      rdy_order.delete();
      lat = 20;
      iq.push_back(mk(1'b0, 1'b0, 28'h0000700, '0));
      exp_q.push_back(mk(1'b0, 1'b0, 28'h0000700, '0));
      for (int n = 0; n < 10 && !mem_read; n++) @(negedge clk);
      chk1("mid_issue_strobe_up", mem_read, 1'b1);
      #2 rst_n = 1'b0;
      #1 chk1("async_drop_mem_read", mem_read, 1'b0);
      chk1("async_no_i_ready", i_ready, 1'b0);
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      lat = 4;
      iq.push_back(mk(1'b0, 1'b0, 28'h0000710, '0));
      exp_q.push_back(mk(1'b0, 1'b0, 28'h0000710, '0));
      wait_done("after_reset");
      chk_order("after_reset", 1, 8'b0);
      chkw("after_reset_i_rdata", i_rdata, {4{4'hC, 28'h0000710}});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

endmodule
